// File: rtl/line_draw_controller.sv
// rtl/line_draw_controller.sv - Bresenham setup and sequencing for one line-drawing fragment generator
module line_draw_controller #(
   parameter int WIDTH = 13,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             line_valid,
   output logic             line_ready,
   input  logic [WIDTH-1:0] xa,
   input  logic [WIDTH-1:0] ya,
   input  logic [WIDTH-1:0] xb,
   input  logic [WIDTH-1:0] yb,
   input  logic             abort,
   input  logic             finish,
   output logic             start,
   output logic             en_FB_reg,
   output logic             steep,
   output logic [WIDTH-1:0] x0,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] x_min,
   output logic [WIDTH-1:0] x_max,
   output logic [WIDTH-1:0] deltax,
   output logic [WIDTH-1:0] deltay,
   output logic [WIDTH-1:0] ystep,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] frag_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_SWAP, S_ORDER, S_START, S_DRAW, S_FLUSH, S_DONE
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0] in_ax, in_ay, in_bx, in_by;
   logic [WIDTH-1:0] sw_ax, sw_ay, sw_bx, sw_by;
   logic             steep_r;
   logic             accept;

   logic [WIDTH-1:0] dx, dy;
   logic             steep_c;
   logic             ends_swap;
   logic [WIDTH-1:0] o_ax, o_ay, o_bx, o_by;

   assign accept = (state == S_IDLE) && line_valid && line_ready;

   always_comb begin
      state_next = state;
      start      = 1'b0;
      en_FB_reg  = 1'b0;
      done       = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE:  if (accept) state_next = S_SWAP;
         S_SWAP:  state_next = abort ? S_DONE : S_ORDER;
         S_ORDER: state_next = abort ? S_DONE : S_START;
         S_START: begin
            start      = 1'b1;
            state_next = abort ? S_DONE : S_DRAW;
         end
         S_DRAW: begin
            en_FB_reg = 1'b1;
            if (abort)       state_next = S_DONE;
            else if (finish) state_next = S_FLUSH;
         end
         S_FLUSH: begin
            en_FB_reg  = 1'b1;
            state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Absolute differences and steepness from the captured endpoints
   always_comb begin
      dx      = (in_bx >= in_ax) ? (in_bx - in_ax) : (in_ax - in_bx);
      dy      = (in_by >= in_ay) ? (in_by - in_ay) : (in_ay - in_by);
      steep_c = (dy > dx);
   end

   always_comb begin
      ends_swap = (sw_ax > sw_bx);
      o_ax      = ends_swap ? sw_bx : sw_ax;
      o_ay      = ends_swap ? sw_by : sw_ay;
      o_bx      = ends_swap ? sw_ax : sw_bx;
      o_by      = ends_swap ? sw_ay : sw_by;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         line_ready <= 1'b1;
         in_ax      <= '0;
         in_ay      <= '0;
         in_bx      <= '0;
         in_by      <= '0;
         sw_ax      <= '0;
         sw_ay      <= '0;
         sw_bx      <= '0;
         sw_by      <= '0;
         steep_r    <= 1'b0;
         steep      <= 1'b0;
         x0         <= '0;
         y0         <= '0;
         x_min      <= '0;
         x_max      <= '0;
         deltax     <= '0;
         deltay     <= '0;
         ystep      <= '0;
         frag_count <= '0;
      end else begin
         state      <= state_next;
         line_ready <= (state_next == S_IDLE);
         if (accept) begin
            in_ax <= xa;
            in_ay <= ya;
            in_bx <= xb;
            in_by <= yb;
         end
         if (state == S_SWAP) begin
            steep_r <= steep_c;
            sw_ax   <= steep_c ? in_ay : in_ax;
            sw_ay   <= steep_c ? in_ax : in_ay;
            sw_bx   <= steep_c ? in_by : in_bx;
            sw_by   <= steep_c ? in_bx : in_by;
         end
         // Configuration is published once and held until the next line's ORDER
         if (state == S_ORDER) begin
            steep  <= steep_r;
            x0     <= o_ax;
            x_min  <= o_ax;
            x_max  <= o_bx;
            y0     <= o_ay;
            deltax <= o_bx - o_ax;
            deltay <= (o_by >= o_ay) ? (o_by - o_ay) : (o_ay - o_by);
            ystep  <= (o_ay > o_by) ? '1 : {{(WIDTH-1){1'b0}}, 1'b1};
         end
         if (accept)
            frag_count <= '0;
         else if (state == S_DRAW && !abort && frag_count != '1)
            frag_count <= frag_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_line_draw_controller.sv
// tb/tb_line_draw_controller.sv - directed self-checking bench for line_draw_controller
module tb_line_draw_controller;

   localparam int WIDTH = 13;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             line_valid;
   logic             line_ready;
   logic [WIDTH-1:0] xa, ya, xb, yb;
   logic             abort, finish;
   logic             start, en_FB_reg, steep;
   logic [WIDTH-1:0] x0, y0, x_min, x_max, deltax, deltay, ystep;
   logic             busy, done;
   logic [CNT_W-1:0] frag_count;

   int checks   = 0;
   int failures = 0;

   line_draw_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .line_valid(line_valid), .line_ready(line_ready),
      .xa(xa), .ya(ya), .xb(xb), .yb(yb),
      .abort(abort), .finish(finish),
      .start(start), .en_FB_reg(en_FB_reg), .steep(steep),
      .x0(x0), .y0(y0), .x_min(x_min), .x_max(x_max),
      .deltax(deltax), .deltay(deltay), .ystep(ystep),
      .busy(busy), .done(done), .frag_count(frag_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a line and returns #1 after the accepting edge (SWAP state)
   task automatic send_line(input int ax, input int ay, input int bx, input int by);
      int n;
      xa = WIDTH'(ax); ya = WIDTH'(ay); xb = WIDTH'(bx); yb = WIDTH'(by);
      line_valid = 1'b1;
      n = 0;
      while (!line_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("accept_timeout", 0, 1);
      tick();
      line_valid = 1'b0;
   endtask

   task automatic check_cfg(input string tag, input int s, input int ex0, input int ey0,
                            input int exmax, input int edx, input int edy, input int eys);
      check({tag, "_steep"}, 32'(steep), 32'(s));
      check({tag, "_x0"}, 32'(x0), 32'(ex0));
      check({tag, "_xmin"}, 32'(x_min), 32'(ex0));
      check({tag, "_y0"}, 32'(y0), 32'(ey0));
      check({tag, "_xmax"}, 32'(x_max), 32'(exmax));
      check({tag, "_dx"}, 32'(deltax), 32'(edx));
      check({tag, "_dy"}, 32'(deltay), 32'(edy));
      check({tag, "_ystep"}, 32'(ystep), 32'(eys));
   endtask

   always @(negedge clk) check("ready_while_busy", 32'(line_ready && busy), 0);

   initial begin
      int en_cnt, done_cnt, done_idx;
      rst = 1'b0; line_valid = 1'b0; abort = 1'b0; finish = 1'b0;
      xa = '0; ya = '0; xb = '0; yb = '0;
      tick(); tick();
      check("rst_ready", 32'(line_ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_start", 32'(start), 0);
      check("rst_en", 32'(en_FB_reg), 0);
      check("rst_done", 32'(done), 0);
      check("rst_ystep", 32'(ystep), 0);
      check("rst_frag", 32'(frag_count), 0);
      rst = 1'b1;
      tick();

      // Line 1: (0,0)->(10,3), 3 DRAW cycles
      send_line(0, 0, 10, 3);
      check("l1_swap_busy", 32'(busy), 1);
      check("l1_swap_start", 32'(start), 0);
      tick();
      check("l1_order_start", 32'(start), 0);
      tick();
      check("l1_start", 32'(start), 1);
      check_cfg("l1", 0, 0, 0, 10, 10, 3, 1);
      tick();
      check("l1_draw_start", 32'(start), 0);
      check("l1_draw_en", 32'(en_FB_reg), 1);
      tick(); tick();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      check("l1_flush_en", 32'(en_FB_reg), 1);
      check("l1_flush_done", 32'(done), 0);
      tick();
      check("l1_done", 32'(done), 1);
      check("l1_done_en", 32'(en_FB_reg), 0);
      tick();
      check("l1_idle_done", 32'(done), 0);
      check("l1_idle_ready", 32'(line_ready), 1);
      check("l1_frag", 32'(frag_count), 3);

      // Line 2: steep, reversed, descending
      send_line(2, 8, 5, 1);
      tick(); tick();
      check_cfg("l2", 1, 1, 5, 8, 7, 3, 32'h1FFF);
      tick();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      tick();
      check("l2_done", 32'(done), 1);
      check("l2_frag", 32'(frag_count), 1);
      tick();

      // Degenerate point with finish already high at DRAW entry
      send_line(4, 4, 4, 4);
      finish = 1'b1;
      en_cnt = 0; done_cnt = 0; done_idx = -1;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) check_cfg("pt", 0, 4, 4, 4, 0, 0, 1);
         if (en_FB_reg) en_cnt++;
         if (done) begin done_cnt++; done_idx = i; end
         tick();
      end
      finish = 1'b0;
      check("pt_en_cycles", 32'(en_cnt), 2);
      check("pt_done_cnt", 32'(done_cnt), 1);
      check("pt_done_idx", 32'(done_idx), 5);
      check("pt_frag", 32'(frag_count), 1);

      // Back-to-back with line_valid held high
      send_line(1, 1, 6, 2);
      xa = 13'd7; ya = 13'd0; xb = 13'd3; yb = 13'd9;
      line_valid = 1'b1;
      tick(); tick();
      check("b2b_l1_dx", 32'(deltax), 5);
      check("b2b_l1_dy", 32'(deltay), 1);
      tick();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      check("b2b_flush_ready", 32'(line_ready), 0);
      tick();
      check("b2b_done", 32'(done), 1);
      check("b2b_done_ready", 32'(line_ready), 0);
      check("b2b_done_dx", 32'(deltax), 5);
      tick();
      check("b2b_idle_busy", 32'(busy), 0);
      check("b2b_idle_ready", 32'(line_ready), 1);
      tick();
      line_valid = 1'b0;
      check("b2b_l2_accepted", 32'(busy), 1);
      check("b2b_l2_swap_dx", 32'(deltax), 5);
      tick();
      check("b2b_l2_order_dx", 32'(deltax), 5);
      tick();
      check_cfg("b2b_l2", 1, 0, 7, 9, 9, 4, 32'h1FFF);
      tick();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      tick(); tick();

      // Abort ignored in IDLE
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle_busy", 32'(busy), 0);
      check("abort_idle_done", 32'(done), 0);

      // Abort and finish together in DRAW
      send_line(0, 0, 3, 3);
      tick(); tick(); tick();
      tick();
      abort = 1'b1; finish = 1'b1;
      tick();
      abort = 1'b0; finish = 1'b0;
      check("ab_done", 32'(done), 1);
      check("ab_en", 32'(en_FB_reg), 0);
      check("ab_frag", 32'(frag_count), 1);
      tick();
      check("ab_idle_done", 32'(done), 0);

      // Asynchronous reset three cycles into DRAW
      send_line(0, 0, 10, 3);
      tick(); tick(); tick();
      tick(); tick();
      check("rs_pre_en", 32'(en_FB_reg), 1);
      #2 rst = 1'b0;
      #1;
      check("rs_ready", 32'(line_ready), 1);
      check("rs_busy", 32'(busy), 0);
      check("rs_en", 32'(en_FB_reg), 0);
      check("rs_start", 32'(start), 0);
      check("rs_done", 32'(done), 0);
      check("rs_frag", 32'(frag_count), 0);
      check("rs_dx", 32'(deltax), 0);
      check("rs_ystep", 32'(ystep), 0);
      tick();
      check("rs_hold_done", 32'(done), 0);
      rst = 1'b1;
      tick();
      check("rs_after_done", 32'(done), 0);
      check("rs_after_ready", 32'(line_ready), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
